// File: rtl/alarm_code_fsm.sv
// Code-lock / alarm sequence detector: matches a 3-bit symbol stream against a short or long code picked by sel.
// Optional build macro ALARM_STICKY_EN makes y latch on the first full match until rst_n is asserted.
module alarm_code_fsm #(
    parameter int                            SYM_W      = 3,
    parameter int                            SHORT_LEN  = 3,
    parameter logic [SHORT_LEN*SYM_W-1:0]    SHORT_CODE = {3'd1, 3'd7, 3'd0},
    parameter int                            LONG_LEN   = 5,
    parameter logic [LONG_LEN*SYM_W-1:0]     LONG_CODE  = {3'd3, 3'd5, 3'd1, 3'd7, 3'd0}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [SYM_W-1:0] x,
    input  logic             sel,
    output logic             y
);

    // Progress states count matched symbols; the encoding supports codes of up to eight symbols.
    typedef enum logic [2:0] {
        S0 = 3'd0,
        S1 = 3'd1,
        S2 = 3'd2,
        S3 = 3'd3,
        S4 = 3'd4,
        S5 = 3'd5,
        S6 = 3'd6,
        S7 = 3'd7
    } state_t;

    state_t           r_state;
    logic             r_sel_q;
    logic             r_y;

    logic [2:0]       w_k;
    logic [2:0]       w_last_idx;
    logic [SYM_W-1:0] w_exp_sym;
    logic [SYM_W-1:0] w_first_sym;
    logic             w_mode_chg;
    logic             w_sym_hit;
    logic             w_full_match;
    logic             w_restart;

    // Symbol idx of the selected code, counted from the first symbol entered (stored in the MSBs).
    function automatic logic [SYM_W-1:0] code_sym(input logic use_short, input logic [2:0] idx);
        int pos;
        if (use_short) begin
            pos = SHORT_LEN - 1 - int'(idx);
            if (pos < 0) begin
                pos = 0;
            end else begin
                pos = pos;
            end
            return SHORT_CODE[pos*SYM_W +: SYM_W];
        end else begin
            pos = LONG_LEN - 1 - int'(idx);
            if (pos < 0) begin
                pos = 0;
            end else begin
                pos = pos;
            end
            return LONG_CODE[pos*SYM_W +: SYM_W];
        end
    endfunction

    // Decode the expected symbol and the match outcome for the current edge.
    always_comb begin
        w_k          = r_state;
        w_last_idx   = r_sel_q ? 3'(SHORT_LEN - 1) : 3'(LONG_LEN - 1);
        w_exp_sym    = code_sym(r_sel_q, w_k);
        w_first_sym  = code_sym(r_sel_q, 3'd0);
        w_mode_chg   = (sel != r_sel_q);
        w_sym_hit    = (x == w_exp_sym);
        w_full_match = 1'b0;
        w_restart    = 1'b0;
        if (!w_mode_chg) begin
            w_full_match = w_sym_hit && (w_k == w_last_idx);
            w_restart    = !w_sym_hit && (x == w_first_sym);
        end else begin
            w_full_match = 1'b0;
            w_restart    = 1'b0;
        end
    end

    // Progress FSM, registered select and registered alarm output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S0;
            r_sel_q <= 1'b0;
            r_y     <= 1'b0;
        end else begin
            r_sel_q <= sel;
            // A select change discards any partial sequence and ignores this cycle's symbol.
            if (w_mode_chg) begin
                r_state <= S0;
            end else if (w_full_match) begin
                r_state <= S0;
            end else if (w_sym_hit) begin
                r_state <= state_t'(w_k + 3'd1);
            end else if (w_restart) begin
                r_state <= S1;
            end else begin
                r_state <= S0;
            end
`ifdef ALARM_STICKY_EN
            if (w_full_match) begin
                r_y <= 1'b1;
            end else begin
                r_y <= r_y;
            end
`else
            r_y <= w_full_match;
`endif
        end
    end

    assign y = r_y;

endmodule

// File: tb/tb_alarm_code_fsm.sv
// Randomized + directed bench for alarm_code_fsm, checked against a symbol-history reference model.
module tb_alarm_code_fsm;

    logic       clk;
    logic       rst_n;
    logic [2:0] x;
    logic       sel;
    logic       y;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: symbols entered since the last clear, registered select, expected y.
    int   hist[$];
    bit   m_sel_q;
    bit   m_y;
    int   short_c[3] = '{1, 7, 0};
    int   long_c[5]  = '{3, 5, 1, 7, 0};

    alarm_code_fsm dut (
        .clk   (clk),
        .rst_n (rst_n),
        .x     (x),
        .sel   (sel),
        .y     (y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic obs, input logic exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: y=%0b expected %0b", tag, $time, obs, exp);
        end
    endtask

    // y is high after an edge exactly when the tail of the history equals the selected code.
    task automatic model_edge(input int xv, input bit sv);
        bit match;
        int len;
        match = 1'b0;
        if (sv != m_sel_q) begin
            hist.delete();
        end else begin
            hist.push_back(xv);
            if (hist.size() > 8) void'(hist.pop_front());
            len = sv ? 3 : 5;
            if (hist.size() >= len) begin
                match = 1'b1;
                for (int i = 0; i < len; i++) begin
                    if (hist[hist.size() - len + i] != (sv ? short_c[i] : long_c[i])) match = 1'b0;
                end
            end
            if (match) hist.delete();
        end
`ifdef ALARM_STICKY_EN
        m_y = m_y | match;
`else
        m_y = match;
`endif
        m_sel_q = sv;
    endtask

    task automatic model_reset();
        hist.delete();
        m_sel_q = 1'b0;
        m_y     = 1'b0;
    endtask

    task automatic step(input int xv, input bit sv, input string tag);
        @(negedge clk);
        x   = 3'(xv);
        sel = sv;
        @(posedge clk);
        model_edge(xv, sv);
        #1;
        check_eq(tag, y, m_y);
    endtask

    task automatic step_code(input bit sv, input string tag);
        if (sv) begin
            for (int i = 0; i < 3; i++) step(short_c[i], sv, tag);
        end else begin
            for (int i = 0; i < 5; i++) step(long_c[i], sv, tag);
        end
    endtask

    // Pulse rst_n low between edges and check y drops without waiting for a clock.
    task automatic async_reset(input string tag);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_eq(tag, y, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int seq_a[7] = '{3, 5, 3, 5, 1, 7, 0};
        int seq_b[6] = '{3, 5, 2, 1, 7, 0};
        bit rs;
        int r;

        rst_n = 1'b0;
        x     = 3'd7;
        sel   = 1'b1;
        model_reset();
        #12;
        check_eq("reset_y", y, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) step(0, 1'b1, "post_reset_idle");

        // Short code, then one trailing symbol.
        step_code(1'b1, "short_code");
        step(0, 1'b1, "short_after");

        // Long code, then short code entered in long mode.
        step(2, 1'b0, "to_long");
        step(2, 1'b0, "long_idle");
        step_code(1'b0, "long_code");
        step(1, 1'b0, "short_in_long");
        step(7, 1'b0, "short_in_long");
        step(0, 1'b0, "short_in_long");

        foreach (seq_a[i]) step(seq_a[i], 1'b0, "restart_seq");
        foreach (seq_b[i]) step(seq_b[i], 1'b0, "broken_seq");

        // Back-to-back long codes with no dead cycle.
        step_code(1'b0, "b2b_long");
        step_code(1'b0, "b2b_long");

        // Mode change mid-sequence, symbol 0 on the change edge is ignored.
        step(1, 1'b1, "mode_chg");
        step(1, 1'b1, "mode_chg");
        step(7, 1'b1, "mode_chg");
        step(0, 1'b0, "mode_chg_edge");
        step_code(1'b0, "after_mode_chg");

        // Async reset mid-code; the remaining tail must not match.
        step(3, 1'b0, "pre_rst");
        step(5, 1'b0, "pre_rst");
        step(1, 1'b0, "pre_rst");
        async_reset("async_rst_y");
        step(7, 1'b0, "post_rst_tail");
        step(0, 1'b0, "post_rst_tail");

        // Randomized mix of noise, injected codes and select toggles.
        rs = 1'b0;
        for (int n = 0; n < 400; n++) begin
            r = int'($urandom_range(0, 19));
            if (r == 0) begin
                rs = ~rs;
                step(int'($urandom_range(0, 7)), rs, "rand_sel");
            end else if (r < 5) begin
                step_code(rs, "rand_code");
            end else if (r < 8) begin
                step(rs ? short_c[$urandom_range(0, 2)] : long_c[$urandom_range(0, 4)], rs, "rand_alpha");
            end else begin
                step(int'($urandom_range(0, 7)), rs, "rand_any");
            end
        end

`ifdef ALARM_STICKY_EN
        async_reset("sticky_pre_rst");
        step(3, 1'b0, "sticky_idle");
        step_code(1'b0, "sticky_match");
        check_eq("sticky_set", y, 1'b1);
        for (int n = 0; n < 10; n++) step(int'($urandom_range(0, 7)), 1'b0, "sticky_hold");
        step(0, 1'b1, "sticky_sel_toggle");
        check_eq("sticky_after_toggle", y, 1'b1);
        async_reset("sticky_clear");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
